// File: rtl/ccd_fifo_pkg.sv
// Shared sizing for the CCD sample FIFO: word width, address width, depth and watermark.
// Imported by the FIFO controller, its bus interface and the bench.
package ccd_fifo_pkg;

    localparam int CCD_DATA_WIDTH   = 16;
    localparam int CCD_ADDR_WIDTH   = 8;
    localparam int CCD_AFULL_THRESH = 224;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    localparam int CCD_DEPTH = fifo_depth(CCD_ADDR_WIDTH);

endpackage

// File: rtl/ccd_fifo_ctrl_if.sv
// Sample-in / word-out handshake bundle for the CCD FIFO.
// The slave modport is the FIFO's view; the master modport is the view of its neighbours.
interface ccd_fifo_ctrl_if
    import ccd_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = CCD_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid
    );

endinterface

// File: rtl/ccd_fifo_ctrl_fifomem.sv
// Dual-port sample buffer: synchronous write, registered (1-cycle) read.
// The array has no reset; its contents are meaningless until written.
module fifomem #(
    parameter int DATASIZE = 16,
    parameter int ADDRSIZE = 8
) (
    input  logic                wclk,
    input  logic                wclken,
    input  logic                wfull,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rclk,
    input  logic                rclken,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ADDRSIZE;

    logic [DATASIZE-1:0] mem [DEPTH];

    always_ff @(posedge wclk) begin
        if (wclken && !wfull) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge rclk) begin
        if (rclken) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ccd_fifo_ctrl.sv
// Single-clock FIFO controller in front of fifomem: pointers, occupancy, flags, sticky overflow.
// The read address is the next read pointer, so the registered read presents words first-word-fall-through.
module ccd_fifo_ctrl
    import ccd_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = CCD_DATA_WIDTH,
    parameter int ADDR_WIDTH   = CCD_ADDR_WIDTH,
    parameter int AFULL_THRESH = CCD_AFULL_THRESH
) (
    input  logic                clk,
    input  logic                rst_n,
    ccd_fifo_ctrl_if.slave      bus,
    input  logic                flush,
    input  logic                clear_ovf,
    output logic [ADDR_WIDTH:0] level,
    output logic                almost_full,
    output logic                overflow
);

    localparam int                  DEPTH     = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH + 1)'(AFULL_THRESH);

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic [ADDR_WIDTH:0] rptr_nxt;
    logic                m_valid_q;
    logic                full;
    logic                push;
    logic                pop;

    assign level       = wptr - rptr;
    assign full        = (level == DEPTH_CNT);
    assign almost_full = (level >= AFULL_CNT);

    assign bus.s_ready = !full && !flush;
    assign bus.m_valid = m_valid_q;

    assign push     = bus.s_valid && bus.s_ready;
    assign pop      = m_valid_q && bus.m_ready && !flush;
    assign rptr_nxt = rptr + {{ADDR_WIDTH{1'b0}}, pop};

    // m_valid looks only at the registered wptr: a word written this edge is readable one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            m_valid_q <= 1'b0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            m_valid_q <= 1'b0;
        end else begin
            wptr      <= wptr + {{ADDR_WIDTH{1'b0}}, push};
            rptr      <= rptr_nxt;
            m_valid_q <= (wptr != rptr_nxt);
        end
    end

    // A new drop outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (bus.s_valid && !bus.s_ready) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    fifomem #(
        .DATASIZE (DATA_WIDTH),
        .ADDRSIZE (ADDR_WIDTH)
    ) u_fifomem (
        .wclk   (clk),
        .wclken (push),
        .wfull  (full),
        .waddr  (wptr[ADDR_WIDTH-1:0]),
        .wdata  (bus.s_data),
        .rclk   (clk),
        .rclken (1'b1),
        .raddr  (rptr_nxt[ADDR_WIDTH-1:0]),
        .rdata  (bus.m_data)
    );

endmodule

// File: tb/tb_ccd_fifo_ctrl.sv
// Self-checking bench for ccd_fifo_ctrl: accepted words go into a scoreboard queue,
// popped words are compared against its head; occupancy and flags are checked per scenario.
module tb_ccd_fifo_ctrl;
    import ccd_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       clear_ovf = 1'b0;
    logic [8:0] level;
    logic       almost_full;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];

    ccd_fifo_ctrl_if #(.DATA_WIDTH(16)) bus ();

    ccd_fifo_ctrl #(
        .DATA_WIDTH   (16),
        .ADDR_WIDTH   (8),
        .AFULL_THRESH (224)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .flush       (flush),
        .clear_ovf   (clear_ovf),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Called at posedge+1 with inputs already driven; samples at posedge+2, returns at next posedge+1.
    task automatic step(output bit pushed, output bit popped, output logic [15:0] pdata);
        #1;
        pushed = bus.s_valid && bus.s_ready;
        popped = bus.m_valid && bus.m_ready && !flush;
        pdata  = bus.m_data;
        if (pushed) exp_q.push_back(bus.s_data);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); end
        checks++; if (level !== 9'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", bus.s_ready); end
    endtask

    task automatic test_single();
        bit pu, po;
        logic [15:0] pd, exp;
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h1234;
        step(pu, po, pd);
        bus.s_valid = 1'b0;
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL single_k1_m_valid got=%b exp=0", bus.m_valid); end
        step(pu, po, pd);
        checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL single_k2_m_valid got=%b exp=1", bus.m_valid); end
        checks++; if (bus.m_data !== 16'h1234) begin failures++; $display("FAIL single_k2_m_data got=%h exp=1234", bus.m_data); end
        checks++; if (level !== 9'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", level); end
        bus.m_ready = 1'b1;
        step(pu, po, pd);
        bus.m_ready = 1'b0;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++; if (!po || pd !== exp) begin failures++; $display("FAIL single_pop got=%h popped=%b exp=%h", pd, po, exp); end
        checks++; if (bus.m_valid !== 1'b0 || level !== 9'd0) begin
            failures++; $display("FAIL single_after_pop m_valid=%b level=%0d exp m_valid=0 level=0", bus.m_valid, level);
        end
    endtask

    task automatic test_fill();
        bit pu, po;
        logic [15:0] pd, exp;
        int budget;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            checks++; if (almost_full !== (exp_q.size() >= 224)) begin
                failures++; $display("FAIL fill_almost_full level=%0d got=%b exp=%b", exp_q.size(), almost_full, exp_q.size() >= 224);
            end
            bus.s_valid = 1'b1;
            bus.s_data  = 16'(i);
            step(pu, po, pd);
        end
        bus.s_valid = 1'b0;
        checks++; if (level !== 9'd256) begin failures++; $display("FAIL fill_level got=%0d exp=256", level); end
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL fill_s_ready got=%b exp=0", bus.s_ready); end
        checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL fill_af_full got=%b exp=1", almost_full); end
        bus.s_valid = 1'b1;
        bus.s_data  = 16'hDEAD;
        step(pu, po, pd);
        bus.s_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
        checks++; if (level !== 9'd256) begin failures++; $display("FAIL fill_level_after_ovf got=%0d exp=256", level); end
        bus.m_ready = 1'b1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 400) begin
            step(pu, po, pd);
            budget++;
            if (po) begin
                exp = exp_q.pop_front();
                checks++; if (pd !== exp) begin failures++; $display("FAIL fill_drain_data got=%h exp=%h", pd, exp); end
            end
        end
        bus.m_ready = 1'b0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL fill_drain_timeout left=%0d exp=0", exp_q.size()); end
        checks++; if (level !== 9'd0 || bus.m_valid !== 1'b0) begin
            failures++; $display("FAIL fill_drain_end level=%0d m_valid=%b exp level=0 m_valid=0", level, bus.m_valid);
        end
    endtask

    task automatic test_streaming();
        bit pu, po;
        logic [15:0] pd, exp;
        int pops_during, outs, bad, budget;
        pops_during = 0; outs = 0; bad = 0;
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            bus.s_data = 16'(16'h1000 + i);
            step(pu, po, pd);
            if (po) begin
                pops_during++; outs++;
                exp = exp_q.pop_front();
                if (pd !== exp) bad++;
            end
        end
        bus.s_valid = 1'b0;
        checks++; if (level !== 9'd2) begin failures++; $display("FAIL stream_level got=%0d exp=2", level); end
        checks++; if (pops_during != 998) begin failures++; $display("FAIL stream_gaps pops=%0d exp=998", pops_during); end
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            step(pu, po, pd);
            budget++;
            if (po) begin
                outs++;
                exp = exp_q.pop_front();
                if (pd !== exp) bad++;
            end
        end
        bus.m_ready = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("FAIL stream_order bad_words=%0d exp=0", bad); end
        checks++; if (outs != 1000) begin failures++; $display("FAIL stream_count got=%0d exp=1000", outs); end
    endtask

    task automatic test_wrap();
        bit pu, po;
        logic [15:0] pd, exp;
        int sent, budget, lvl_bad, data_bad, outs;
        sent = 0; budget = 0; lvl_bad = 0; data_bad = 0; outs = 0;
        while ((sent < 600 || exp_q.size() > 0) && budget < 5000) begin
            if (level !== 9'(exp_q.size())) lvl_bad++;
            bus.s_valid = (sent < 600) && ($urandom_range(0, 2) != 0);
            bus.s_data  = 16'(16'h4000 + sent);
            bus.m_ready = ($urandom_range(0, 2) != 0);
            step(pu, po, pd);
            budget++;
            if (pu) sent++;
            if (po) begin
                outs++;
                exp = exp_q.pop_front();
                if (pd !== exp) data_bad++;
            end
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        checks++; if (lvl_bad != 0) begin failures++; $display("FAIL wrap_level mismatched_cycles=%0d exp=0", lvl_bad); end
        checks++; if (data_bad != 0) begin failures++; $display("FAIL wrap_order bad_words=%0d exp=0", data_bad); end
        checks++; if (outs != 600) begin failures++; $display("FAIL wrap_count got=%0d exp=600", outs); end
    endtask

    task automatic test_flush_ovf();
        bit pu, po;
        logic [15:0] pd;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 16'(16'h7000 + i);
            step(pu, po, pd);
        end
        bus.s_valid = 1'b0;
        step(pu, po, pd);
        checks++; if (level !== 9'd10 || overflow !== 1'b1) begin
            failures++; $display("FAIL flush_pre level=%0d ovf=%b exp level=10 ovf=1", level, overflow);
        end
        flush = 1'b1;
        bus.m_ready = 1'b1;
        step(pu, po, pd);
        flush = 1'b0;
        bus.m_ready = 1'b0;
        exp_q.delete();
        checks++; if (level !== 9'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", level); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL flush_m_valid got=%b exp=0", bus.m_valid); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL flush_keeps_ovf got=%b exp=1", overflow); end
        flush = 1'b1; bus.s_valid = 1'b1; clear_ovf = 1'b1; bus.s_data = 16'hBEEF;
        step(pu, po, pd);
        flush = 1'b0; bus.s_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
        checks++; if (level !== 9'd0) begin failures++; $display("FAIL flush_no_store level=%0d exp=0", level); end
        step(pu, po, pd);
        clear_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_async_reset();
        bit pu, po;
        logic [15:0] pd;
        bus.m_ready = 1'b0;
        flush = 1'b1; bus.s_valid = 1'b1; bus.s_data = 16'h0BAD;
        step(pu, po, pd);
        flush = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            bus.s_data = 16'(16'h5000 + i);
            step(pu, po, pd);
        end
        bus.s_valid = 1'b0;
        step(pu, po, pd);
        step(pu, po, pd);
        checks++; if (bus.m_valid !== 1'b1 || overflow !== 1'b1 || level !== 9'd5) begin
            failures++; $display("FAIL arst_pre m_valid=%b ovf=%b level=%0d exp 1 1 5", bus.m_valid, overflow, level);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL arst_m_valid got=%b exp=0", bus.m_valid); end
        checks++; if (level !== 9'd0) begin failures++; $display("FAIL arst_level got=%0d exp=0", level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL arst_overflow got=%b exp=0", overflow); end
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_single();
    endtask

    initial begin
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_single();
        test_fill();
        test_streaming();
        test_wrap();
        test_flush_ovf();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ccd_fifo_ctrl.md
Name: ccd_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences the dual-port `fifomem` buffer between the CCD ADC sample writer and the downstream readout/host interface.
- Owns the write and read pointers, occupancy, full/empty decisions and the almost-full watermark.
- Hides the memory's 1-cycle registered read with a first-word-fall-through output.
- The ADC side cannot stall, so dropped samples are flagged in a sticky overflow bit.

Parameters:
DATA_WIDTH, 16, sample word width
ADDR_WIDTH, 8, memory address width; DEPTH = 2^ADDR_WIDTH words
AFULL_THRESH, 224, occupancy at or above which almost_full asserts

Ports:
clk  in  1  single clock for all logic; drives both memory clocks
rst_n  in  1  asynchronous, active-low reset
s_data  in  DATA_WIDTH  write data from ADC path
s_valid  in  1  write request
s_ready  out  1  write accepted when s_valid & s_ready
m_data  out  DATA_WIDTH  read data (FWFT), valid when m_valid
m_valid  out  1  output word available
m_ready  in  1  consumer takes word when m_valid & m_ready
flush  in  1  synchronous clear of FIFO contents
clear_ovf  in  1  clears sticky overflow
level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
almost_full  out  1  level >= AFULL_THRESH
overflow  out  1  sticky: write attempted while not ready

Behaviour:
- Reset (async, rst_n=0): wptr=rptr=0, m_valid=0, overflow=0, level=0, almost_full=0, s_ready=1. m_data and memory contents are undefined while m_valid=0.
- Pointers: wptr and rptr are ADDR_WIDTH+1 bits and wrap modulo 2^(ADDR_WIDTH+1). Memory address = low ADDR_WIDTH bits.
- Occupancy and flags:
  - level = wptr - rptr. This count includes the word currently presented on m_data.
  - full = (level == DEPTH). empty = (level == 0).
  - level, almost_full and s_ready are combinational from registers only (no input paths), except that s_ready also depends on flush.
- Write path:
  - s_ready = !full & !flush.
  - push = s_valid & s_ready. On push: mem[wptr] <= s_data, wptr += 1.
  - Memory wclken = push; memory wfull input is tied to full.
- Read path:
  - pop = m_valid & m_ready. rptr_nxt = rptr + pop.
  - Memory raddr = rptr_nxt (combinational), so mem_rdata after the edge is the word at the new rptr. m_data = mem_rdata directly.
  - m_valid register <= (wptr != rptr_nxt), using registered wptr. A push in the same cycle does not count.
- Latency: a word accepted in cycle k appears on m_valid/m_data in cycle k+2. No read-during-write hazard exists, because a write lands one edge before its address can be read.
- Throughput: one push and one pop per cycle, sustained. Simultaneous push and pop leave level unchanged.
- Full: no push while full, even if a pop happens in the same cycle (no pass-through). s_ready rises the cycle after the pop.
- Empty: m_valid=0, and m_ready is ignored.
- Overflow: set when s_valid & !s_ready, including during flush. Cleared by clear_ovf. If set and clear happen in the same cycle, set wins. flush does not affect overflow.
- Flush:
  - In the flush cycle, push and pop are suppressed.
  - At the next edge, wptr=rptr=0 and m_valid=0, so level=0 the cycle after flush.
- Reset mid-operation: all state is cleared immediately and asynchronously. In-flight data is lost.

Decomposition:
- Shared package/include ccd_fifo_pkg:
  - default CCD sample width (16) and FIFO address width (8);
  - DEPTH derivation;
  - default watermark.
- One sub-module: fifomem instance with rclk=wclk=clk, rclken=1, wclken=push, wfull=full.
- All pointer, flag and overflow logic stays in ccd_fifo_ctrl.

Test Plan:
- Single word: after reset, push 0x1234 in cycle k -> m_valid=1 and m_data=0x1234 in cycle k+2, level=1. Pop -> m_valid=0 and level=0 next cycle.
- Fill with m_ready=0:
  - push 256 words 0..255 -> almost_full from level 224, s_ready=0 at level 256;
  - 257th s_valid -> overflow=1, data not stored;
  - drain -> 0..255 in order.
- Streaming: s_valid=m_ready=1 continuously for 1000 incrementing words -> in-order output, no gaps after 2-cycle latency, level settles at 2.
- Wrap with stalls: 600 words, random s_valid/m_ready -> in order, level always equals scoreboard count, pointers wrap past 511.
- Flush and overflow clearing:
  - flush at level 10 with overflow=1 -> level=0 and m_valid=0 next cycle, overflow still 1;
  - clear_ovf concurrent with a new overflow event -> overflow stays 1;
  - clear_ovf alone -> overflow 0.
- Async reset: assert rst_n=0 mid-stream between edges -> m_valid, level, overflow go to 0 immediately. After release, the first push behaves as in scenario 1.
